// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-side drain engine for an 8-bit FIFO. Issues a registered read enable
//   while the FIFO has data, captures the returned bytes, packs BYTES of them
//   little-endian into one output word and offers that word on a valid/ready
//   handshake. A flush pulse emits any partially assembled word with a keep
//   mask, so packet tails are not stranded in the assembly buffer.
//
// Parameters
//   BYTES     bytes per output word, legal range 1..4
//
// Ports
//   clkr      in   read-domain clock, rising edge
//   rrst_n    in   asynchronous active-low reset
//   flage     in   FIFO empty flag
//   flagae    in   FIFO almost-empty flag (exactly one entry left)
//   dout      in   FIFO read data, valid the cycle after re
//   re        out  FIFO read enable (registered)
//   flush     in   one-cycle request to emit a partial word
//   m_data    out  packed word, first byte in bits [7:0]
//   m_keep    out  per-byte valid mask
//   m_valid   out  word available
//   m_ready   in   downstream accept
//   rd_count  out  bytes captured since reset, wraps at 16 bits
module fifo_rd_packer #(
  parameter int BYTES = 2
) (
  input  logic               clkr,
  input  logic               rrst_n,
  input  logic               flage,
  input  logic               flagae,
  input  logic [7:0]         dout,
  output logic               re,
  input  logic               flush,
  output logic [8*BYTES-1:0] m_data,
  output logic [BYTES-1:0]   m_keep,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [15:0]        rd_count
);

  localparam logic [2:0] FULL = 3'(BYTES);

  logic [BYTES-1:0][7:0] asm_q, asm_d;
  logic [2:0]            fill_q, fill_d;
  logic                  rd_pend_q;
  logic                  re_q, re_d;
  logic                  start_q;
  logic                  flush_pend_q, flush_pend_d;
  logic [8*BYTES-1:0]    m_data_q, m_data_d;
  logic [BYTES-1:0]      m_keep_q, m_keep_d;
  logic                  m_valid_q, m_valid_d;
  logic [15:0]           rd_count_q, rd_count_d;

  logic [2:0]            fill_cap;
  logic [2:0]            inflight;
  logic                  out_free;
  logic                  flush_req;
  logic                  room;
  logic [BYTES-1:0]      part_keep;

  // Keep mask for a partial word: the low fill_q lanes.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_keep
      assign part_keep[gi] = (fill_q > 3'(gi));
    end
  endgenerate

  always_comb begin
    asm_d        = asm_q;
    fill_cap     = fill_q;
    rd_count_d   = rd_count_q;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    m_valid_d    = m_valid_q & ~m_ready;
    out_free     = ~m_valid_q | m_ready;
    flush_req    = flush_pend_q | flush;
    flush_pend_d = flush_req;

    // Capture the byte returned for last cycle's read into lane fill_q.
    if (rd_pend_q) begin
      for (int i = 0; i < BYTES; i++) begin
        if (fill_q == 3'(i)) begin
          asm_d[i] = dout;
        end
      end
      fill_cap   = fill_q + 3'd1;
      rd_count_d = rd_count_q + 16'd1;
    end
    fill_d = fill_cap;

    // Lanes above fill are always zero because asm is cleared on every
    // transfer, so a partial word needs no extra masking of its data.
    if ((fill_cap == FULL) && out_free) begin
      m_data_d  = asm_d;
      m_keep_d  = '1;
      m_valid_d = 1'b1;
      fill_d    = 3'd0;
      asm_d     = '0;
    end else if (flush_req && !rd_pend_q && out_free) begin
      flush_pend_d = 1'b0;
      if (fill_q != 3'd0) begin
        m_data_d  = asm_q;
        m_keep_d  = part_keep;
        m_valid_d = 1'b1;
        fill_d    = 3'd0;
        asm_d     = '0;
      end
    end

    // Bytes that will occupy asm once the current read (re_q) lands.
    // A read beyond that is only safe when the in-flight byte completes a
    // word that is guaranteed to find the output register empty, which
    // keeps one byte per cycle in steady state without ever overrunning asm.
    inflight = fill_d + {2'b00, re_q};
    room     = (inflight < FULL) ||
               ((inflight == FULL) && re_q && !m_valid_d);

    // No back-to-back read on the last FIFO entry; start_q holds off the
    // first read for one cycle after reset release.
    re_d = start_q && !flage && !flush_pend_d && room && !(flagae && re_q);
  end

  always_ff @(posedge clkr or negedge rrst_n) begin
    if (!rrst_n) begin
      asm_q        <= '0;
      fill_q       <= 3'd0;
      rd_pend_q    <= 1'b0;
      re_q         <= 1'b0;
      start_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_valid_q    <= 1'b0;
      rd_count_q   <= 16'd0;
    end else begin
      asm_q        <= asm_d;
      fill_q       <= fill_d;
      rd_pend_q    <= re_q;
      re_q         <= re_d;
      start_q      <= 1'b1;
      flush_pend_q <= flush_pend_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_valid_q    <= m_valid_d;
      rd_count_q   <= rd_count_d;
    end
  end

  assign re       = re_q;
  assign m_data   = m_data_q;
  assign m_keep   = m_keep_q;
  assign m_valid  = m_valid_q;
  assign rd_count = rd_count_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer (BYTES=2). A queue-based FIFO model feeds the
// DUT; every byte written is also pushed to an expected-byte queue that an
// independent monitor drains as words are accepted downstream.
module tb_fifo_rd_packer;

  logic        clkr = 1'b0;
  logic        rrst_n;
  logic        flage, flagae;
  logic [7:0]  dout;
  logic        re;
  logic        flush;
  logic [15:0] m_data;
  logic [1:0]  m_keep;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] rd_count;

  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] acc_d[$];
  logic [1:0]  acc_k[$];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          re_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  fifo_rd_packer #(.BYTES(2)) dut (
    .clkr(clkr), .rrst_n(rrst_n), .flage(flage), .flagae(flagae),
    .dout(dout), .re(re), .flush(flush), .m_data(m_data), .m_keep(m_keep),
    .m_valid(m_valid), .m_ready(m_ready), .rd_count(rd_count)
  );

  initial forever #5 clkr = ~clkr;

  assign flage  = (wr_cnt == rd_cnt);
  assign flagae = ((wr_cnt - rd_cnt) == 1);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clkr);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    wr_cnt++;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic wait_acc(input string name, input int n);
    int t = 0;
    while (acc_d.size() < n && t < 100) begin
      tick(1);
      t++;
    end
    chk(name, 32'(acc_d.size() >= n), 32'd1);
  endtask

  // FIFO model: registered read data, discarded by reset.
  initial begin
    dout = 8'h00;
    forever begin
      @(posedge clkr);
      if (!rrst_n) begin
        fifo_q.delete();
        rd_cnt <= wr_cnt;
      end else if (re && fifo_q.size() > 0) begin
        dout   <= fifo_q.pop_front();
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic        hold_v = 1'b0;
    logic [15:0] hold_d = '0;
    logic [1:0]  hold_k = '0;
    logic        last_rd = 1'b0;
    forever begin
      @(negedge clkr);
      if (!rrst_n) begin
        exp_q.delete();
        hold_v  = 1'b0;
        last_rd = 1'b0;
      end else begin
        if (re) begin
          re_cnt++;
          chk("re_while_empty", 32'(flage), 32'd0);
        end
        if (last_rd) chk("re_back_to_back_last", 32'(re), 32'd0);
        last_rd = re && flagae;
        if (hold_v) begin
          chk("hold_valid", 32'(m_valid), 32'd1);
          chk("hold_data", 32'(m_data), 32'(hold_d));
          chk("hold_keep", 32'(m_keep), 32'(hold_k));
        end
        hold_v = m_valid && !m_ready;
        hold_d = m_data;
        hold_k = m_keep;
        if (m_valid && m_ready) begin
          acc_d.push_back(m_data);
          acc_k.push_back(m_keep);
          chk("keep_form", 32'((m_keep != 2'b00) && ((m_keep & (m_keep + 2'b01)) == 2'b00)), 32'd1);
          for (int i = 0; i < 2; i++) begin
            if (m_keep[i]) begin
              if (exp_q.size() == 0) begin
                chk("extra_byte", 32'(m_data[8*i +: 8]), 32'hFFFF_FFFF);
              end else begin
                chk("byte_order", 32'(m_data[8*i +: 8]), 32'(exp_q.pop_front()));
              end
            end else begin
              chk("unused_lane_zero", 32'(m_data[8*i +: 8]), 32'd0);
            end
          end
        end
      end
    end
  end

  initial begin
    int t;
    int re0;
    logic [15:0] rc0;
    rrst_n  = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;

    // Reset state
    tick(3);
    chk("rst_re", 32'(re), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_keep", 32'(m_keep), 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    rrst_n = 1'b1;

    // Basic fill
    acc_d.delete(); acc_k.delete();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    wait_acc("basic_timeout", 2);
    chk("basic_w0", 32'(acc_d[0]), 32'h2211);
    chk("basic_k0", 32'(acc_k[0]), 32'h3);
    chk("basic_w1", 32'(acc_d[1]), 32'h4433);
    chk("basic_k1", 32'(acc_k[1]), 32'h3);
    chk("basic_rd_count", 32'(rd_count), 32'd4);

    // Backpressure
    acc_d.delete(); acc_k.delete();
    m_ready = 1'b0;
    re0 = re_cnt;
    rc0 = rd_count;
    for (int i = 1; i <= 6; i++) push_byte(8'(i));
    tick(20);
    chk("bp_reads", 32'(re_cnt - re0), 32'd4);
    chk("bp_rd_count", 32'(rd_count - rc0), 32'd4);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_data", 32'(m_data), 32'h0201);
    m_ready = 1'b1;
    wait_acc("bp_timeout", 3);
    chk("bp_w0", 32'(acc_d[0]), 32'h0201);
    chk("bp_w1", 32'(acc_d[1]), 32'h0403);
    chk("bp_w2", 32'(acc_d[2]), 32'h0605);
    chk("bp_total", 32'(rd_count - rc0), 32'd6);

    // Last-entry rule, then flush the lone byte out
    acc_d.delete(); acc_k.delete();
    re0 = re_cnt;
    rc0 = rd_count;
    push_byte(8'h77);
    tick(10);
    chk("last_reads", 32'(re_cnt - re0), 32'd1);
    chk("last_rd_count", 32'(rd_count - rc0), 32'd1);
    chk("last_no_word", 32'(acc_d.size()), 32'd0);
    pulse_flush();
    tick(5);
    chk("last_flush_words", 32'(acc_d.size()), 32'd1);
    chk("last_flush_data", 32'(acc_d[0]), 32'h0077);
    chk("last_flush_keep", 32'(acc_k[0]), 32'h1);

    // Flush partial
    acc_d.delete(); acc_k.delete();
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
    tick(10);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("flush_latency_valid", 32'(m_valid), 32'd1);
    chk("flush_latency_keep", 32'(m_keep), 32'h1);
    tick(4);
    chk("flush_words", 32'(acc_d.size()), 32'd2);
    chk("flush_w0", 32'(acc_d[0]), 32'hB2A1);
    chk("flush_k0", 32'(acc_k[0]), 32'h3);
    chk("flush_w1", 32'(acc_d[1]), 32'h00C3);
    chk("flush_k1", 32'(acc_k[1]), 32'h1);
    acc_d.delete(); acc_k.delete();
    pulse_flush();
    tick(10);
    chk("flush_empty_words", 32'(acc_d.size()), 32'd0);
    chk("flush_empty_valid", 32'(m_valid), 32'd0);

    // Reset while a read is in flight and a word is held
    acc_d.delete(); acc_k.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    t = 0;
    while (!(m_valid && re) && t < 50) begin
      @(negedge clkr);
      t++;
    end
    chk("rstmid_setup_timeout", 32'(m_valid && re), 32'd1);
    @(posedge clkr);
    #1;
    rrst_n = 1'b0;
    #1;
    chk("rstmid_re", 32'(re), 32'd0);
    chk("rstmid_valid", 32'(m_valid), 32'd0);
    chk("rstmid_data", 32'(m_data), 32'd0);
    chk("rstmid_keep", 32'(m_keep), 32'd0);
    chk("rstmid_rd_count", 32'(rd_count), 32'd0);
    tick(2);
    m_ready = 1'b1;
    rrst_n = 1'b1;
    acc_d.delete(); acc_k.delete();
    push_byte(8'h5A); push_byte(8'hA5);
    tick(1);
    chk("rstmid_first_edge_re", 32'(re), 32'd0);
    wait_acc("rstmid_resume_timeout", 1);
    chk("rstmid_resume_word", 32'(acc_d[0]), 32'hA55A);
    chk("rstmid_resume_keep", 32'(acc_k[0]), 32'h3);
    chk("rstmid_resume_count", 32'(rd_count), 32'd2);

    // Counter wrap
    for (int i = 0; i < 65533; i++) push_byte(8'($urandom));
    t = 0;
    while (rd_count != 16'hFFFF && t < 70000) begin
      tick(1);
      t++;
    end
    chk("wrap_reach_ffff", 32'(rd_count), 32'hFFFF);
    tick(5);
    chk("wrap_hold_ffff", 32'(rd_count), 32'hFFFF);
    push_byte(8'($urandom));
    tick(6);
    chk("wrap_zero", 32'(rd_count), 32'h0000);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);

    // Randomized traffic with backpressure and flushes
    for (int cyc = 0; cyc < 1500; cyc++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) push_byte(8'($urandom));
      flush = ($urandom_range(0, 39) == 0);
      tick(1);
    end
    flush   = 1'b0;
    m_ready = 1'b1;
    t = 0;
    while (wr_cnt != rd_cnt && t < 500) begin
      tick(1);
      t++;
    end
    chk("rand_fifo_drained", 32'(wr_cnt == rd_cnt), 32'd1);
    tick(4);
    pulse_flush();
    tick(6);
    chk("rand_all_bytes_out", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
